// File: rtl/cm_piso.sv
// cm_piso: parallel-in serial-out converter, LEN elements per word, valid/ready on both sides.
// Optional o_last output enabled by defining CM_PISO_LAST_EN.
module cm_piso #(
   parameter int unsigned LEN       = 4,
   parameter type         DTYPE     = logic [7:0],
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  DTYPE [LEN-1:0] i_data,
   input  logic           i_valid,
   output logic           o_ready,
   output DTYPE           o_data,
   output logic           o_valid,
   input  logic           i_ready
`ifdef CM_PISO_LAST_EN
   ,
   output logic           o_last
`endif
);
   if (LEN < 1) begin : g_bad_len
      $error("cm_piso: LEN must be >= 1");
   end
   localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d, idx;
   DTYPE [LEN-1:0] word_q, word_d;
   logic           at_last, load, consume;
   assign at_last = cnt_q == LAST;
   assign o_valid = state_q == SHIFT;
   assign o_ready = (state_q == IDLE) || (at_last && i_ready);
   assign load    = i_valid && o_ready;
   assign consume = o_valid && i_ready;
   assign idx     = LSB_FIRST ? cnt_q : LAST - cnt_q;
   assign o_data  = o_valid ? word_q[idx] : '0;
`ifdef CM_PISO_LAST_EN
   assign o_last  = o_valid && at_last;
`endif
   // a load in SHIFT only happens together with consuming the last element
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      if (load) begin
         state_d = SHIFT;
         cnt_d   = '0;
         word_d  = i_data;
      end else if (consume) begin
         state_d = at_last ? IDLE : SHIFT;
         cnt_d   = at_last ? cnt_q : cnt_q + 1'b1;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end
endmodule

// File: tb/tb_cm_piso.sv
// tb_cm_piso: directed bench for cm_piso (LEN 4 both orders, LEN 1 slice).
module tb_cm_piso;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0][7:0]  d4 = '0;
   logic             v4 = 1'b0, ir4 = 1'b1;
   logic             r4, r4m, qv4, qv4m;
   logic [7:0]       q4, q4m;
   logic [0:0][7:0]  d1 = '0;
   logic             v1 = 1'b0, ir1 = 1'b0;
   logic             r1, qv1;
   logic [7:0]       q1;
   int               checks = 0;
   int               errors = 0;
`ifdef CM_PISO_LAST_EN
   logic             l4, l4m, l1;
`endif
   localparam logic [3:0][7:0] WA = {8'h44, 8'h33, 8'h22, 8'h11};
   localparam logic [3:0][7:0] WB = {8'h88, 8'h77, 8'h66, 8'h55};

   always #5 clk = ~clk;

   cm_piso #(.LEN(4), .LSB_FIRST(1'b1)) u_lsb (
      .i_clk(clk), .i_rst(rst), .i_data(d4), .i_valid(v4), .o_ready(r4),
      .o_data(q4), .o_valid(qv4), .i_ready(ir4)
`ifdef CM_PISO_LAST_EN
      , .o_last(l4)
`endif
   );
   cm_piso #(.LEN(4), .LSB_FIRST(1'b0)) u_msb (
      .i_clk(clk), .i_rst(rst), .i_data(d4), .i_valid(v4), .o_ready(r4m),
      .o_data(q4m), .o_valid(qv4m), .i_ready(ir4)
`ifdef CM_PISO_LAST_EN
      , .o_last(l4m)
`endif
   );
   cm_piso #(.LEN(1)) u_one (
      .i_clk(clk), .i_rst(rst), .i_data(d1), .i_valid(v1), .o_ready(r1),
      .o_data(q1), .o_valid(qv1), .i_ready(ir1)
`ifdef CM_PISO_LAST_EN
      , .o_last(l1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_l [8];
      logic [7:0] exp_m [8];
      logic [7:0] w1 [4];
      int nload, ncons;
      exp_l = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      exp_m = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
      w1    = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      // reset
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_valid", {31'd0, qv4}, 32'd0);
      chk("rst_data", {24'd0, q4}, 32'd0);
      chk("rst_ready", {31'd0, r4}, 32'd1);
      chk("rst_valid1", {31'd0, qv1}, 32'd0);
`ifdef CM_PISO_LAST_EN
      chk("rst_last", {31'd0, l4}, 32'd0);
`endif
      // single word, both emission orders
      d4 = WA;
      v4 = 1'b1;
      cyc();
      v4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("single_valid", {31'd0, qv4}, 32'd1);
         chk("single_lsb", {24'd0, q4}, {24'd0, exp_l[i]});
         chk("single_msb", {24'd0, q4m}, {24'd0, exp_m[i]});
         chk("single_ready", {31'd0, r4}, (i == 3) ? 32'd1 : 32'd0);
`ifdef CM_PISO_LAST_EN
         chk("single_last", {31'd0, l4}, (i == 3) ? 32'd1 : 32'd0);
         chk("single_last_m", {31'd0, l4m}, (i == 3) ? 32'd1 : 32'd0);
`endif
         cyc();
      end
      chk("single_end", {31'd0, qv4}, 32'd0);
      chk("single_end_data", {24'd0, q4}, 32'd0);
      // back-to-back: second load coincides with first word's last element
      d4 = WA;
      v4 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (i == 0) d4 = WB;
         if (i == 4) v4 = 1'b0;
         chk("b2b_valid", {31'd0, qv4}, 32'd1);
         chk("b2b_lsb", {24'd0, q4}, {24'd0, exp_l[i]});
         chk("b2b_msb", {24'd0, q4m}, {24'd0, exp_m[i]});
         if (i == 3) chk("b2b_ready_at_last", {31'd0, r4}, 32'd1);
         if (i == 2) chk("b2b_ready_mid", {31'd0, r4}, 32'd0);
      end
      cyc();
      chk("b2b_end", {31'd0, qv4}, 32'd0);
      // stall on element 22, with a competing word offered
      d4 = WA;
      v4 = 1'b1;
      cyc();
      v4 = 1'b0;
      cyc();
      chk("stall_pre", {24'd0, q4}, 32'h22);
      ir4 = 1'b0;
      v4 = 1'b1;
      d4 = WB;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_data", {24'd0, q4}, 32'h22);
         chk("stall_data_m", {24'd0, q4m}, 32'h33);
         chk("stall_valid", {31'd0, qv4}, 32'd1);
         chk("stall_ready", {31'd0, r4}, 32'd0);
      end
      ir4 = 1'b1;
      v4 = 1'b0;
      cyc();
      chk("stall_after1", {24'd0, q4}, 32'h33);
      cyc();
      chk("stall_after2", {24'd0, q4}, 32'h44);
      cyc();
      chk("stall_end", {31'd0, qv4}, 32'd0);
      // reset mid-word, at the edge that consumes 22
      d4 = WA;
      v4 = 1'b1;
      cyc();
      v4 = 1'b0;
      cyc();
      chk("midrst_pre", {24'd0, q4}, 32'h22);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_valid", {31'd0, qv4}, 32'd0);
      chk("midrst_data", {24'd0, q4}, 32'd0);
      cyc();
      chk("midrst_quiet", {31'd0, qv4}, 32'd0);
      d4 = WB;
      v4 = 1'b1;
      cyc();
      v4 = 1'b0;
      chk("midrst_reload", {24'd0, q4}, 32'h55);
      for (int i = 0; i < 4; i++) cyc();
      chk("midrst_end", {31'd0, qv4}, 32'd0);
      // LEN 1 slice with i_ready toggling
      nload = 0;
      ncons = 0;
      for (int i = 0; i < 24; i++) begin
         v1 = nload < 4;
         d1 = (nload < 4) ? w1[nload] : 8'h00;
         ir1 = (i % 3) != 0;
         #1;
         if (qv1 && !ir1) chk("one_ready_stall", {31'd0, r1}, 32'd0);
`ifdef CM_PISO_LAST_EN
         chk("one_last", {31'd0, l1}, {31'd0, qv1});
`endif
         if (qv1 && ir1) begin
            chk("one_data", {24'd0, q1}, (ncons < 4) ? {24'd0, w1[ncons]} : 32'hFFFF_FFFF);
            ncons++;
         end
         if (v1 && r1) nload++;
         cyc();
      end
      chk("one_loads", nload, 32'd4);
      chk("one_consumed", ncons, 32'd4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
